// File: rtl/zip_fetch_mem_arbiter.sv
// Two-master Wishbone arbiter: data (B) over fetch (A), with a
// starvation counter that eventually forces a fetch grant.
module zip_fetch_mem_arbiter #(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 8,
  parameter int LGSTARVE   = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_ack,
  output logic          o_a_err,
  output logic          o_a_stall,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_ack,
  output logic          o_b_err,
  output logic          o_b_stall,
  output logic          o_cyc,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  input  logic          i_ack,
  input  logic          i_err,
  input  logic          i_stall,
  output logic [1:0]    o_owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_e;

  localparam logic [LGSTARVE-1:0] LIM = LGSTARVE'(STARVE_LIM);

  state_e              state_q, state_d;
  logic [LGSTARVE-1:0] starve_q, starve_d;
  logic                arb;
  logic                a_starved;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Arbitrate only when the bus is free or its owner has ended its cycle
  always_comb begin
    arb       = 1'b0;
    a_starved = i_a_cyc && (starve_q == LIM);
    state_d   = state_q;
    starve_d  = starve_q;
    unique case (1'b1)
      state_q == OWN_A: arb = !i_a_cyc;
      state_q == OWN_B: arb = !i_b_cyc;
      default:          arb = 1'b1;
    endcase
    if (arb) begin
      if (i_b_cyc && !a_starved) begin
        state_d = OWN_B;
        if (i_a_cyc && starve_q != LIM)
          starve_d = starve_q + 1'b1;
      end else if (i_a_cyc) begin
        state_d  = OWN_A;
        starve_d = '0;
      end else begin
        state_d = IDLE;
      end
    end
    if (!i_a_cyc)
      starve_d = '0;
  end

  always_comb begin
    o_cyc     = 1'b0;
    o_stb     = 1'b0;
    o_we      = i_a_we;
    o_addr    = i_a_addr;
    o_data    = i_a_data;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_a_stall = 1'b1;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    o_b_stall = 1'b1;
    o_owner   = state_q;
    unique case (1'b1)
      state_q == OWN_A: begin
        o_cyc     = i_a_cyc;
        o_stb     = i_a_stb;
        o_a_stall = i_stall;
        o_a_ack   = i_ack & i_a_cyc;
        o_a_err   = i_err & i_a_cyc;
      end
      state_q == OWN_B: begin
        o_cyc     = i_b_cyc;
        o_stb     = i_b_stb;
        o_we      = i_b_we;
        o_addr    = i_b_addr;
        o_data    = i_b_data;
        o_b_stall = i_stall;
        o_b_ack   = i_ack & i_b_cyc;
        o_b_err   = i_err & i_b_cyc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_zip_fetch_mem_arbiter.sv
// Bench for zip_fetch_mem_arbiter: random and directed stimulus,
// expected bus outputs queued per cycle and checked by a monitor.
module tb_zip_fetch_mem_arbiter;

  localparam int AW  = 24;
  localparam int DW  = 32;
  localparam int LIM = 8;
  localparam int LG  = 4;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_a_cyc, i_a_stb, i_a_we;
  logic [AW-1:0] i_a_addr;
  logic [DW-1:0] i_a_data;
  logic          o_a_ack, o_a_err, o_a_stall;
  logic          i_b_cyc, i_b_stb, i_b_we;
  logic [AW-1:0] i_b_addr;
  logic [DW-1:0] i_b_data;
  logic          o_b_ack, o_b_err, o_b_stall;
  logic          o_cyc, o_stb, o_we;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          i_ack, i_err, i_stall;
  logic [1:0]    o_owner;

  always #5 clk = ~clk;

  zip_fetch_mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIM(LIM), .LGSTARVE(LG)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we),
    .i_a_addr(i_a_addr), .i_a_data(i_a_data),
    .o_a_ack(o_a_ack), .o_a_err(o_a_err), .o_a_stall(o_a_stall),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we),
    .i_b_addr(i_b_addr), .i_b_data(i_b_data),
    .o_b_ack(o_b_ack), .o_b_err(o_b_err), .o_b_stall(o_b_stall),
    .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we),
    .o_addr(o_addr), .o_data(o_data),
    .i_ack(i_ack), .i_err(i_err), .i_stall(i_stall),
    .o_owner(o_owner)
  );

  typedef struct {
    logic          cyc, stb, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          a_ack, a_err, a_stall;
    logic          b_ack, b_err, b_stall;
    logic [1:0]    owner;
    int            starve;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_owner  = 0;
  int   m_starve = 0;

  task automatic chk(input string n, input longint unsigned act,
                     input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // Reference: who holds the bus follows the grant rules directly
  task automatic model_edge();
    bit arb;
    int g;
    if (!i_rst_n) begin
      m_owner  = 0;
      m_starve = 0;
      return;
    end
    arb = (m_owner == 0) || (m_owner == 1 && !i_a_cyc) ||
          (m_owner == 2 && !i_b_cyc);
    g = m_owner;
    if (arb) begin
      if (i_b_cyc && !(i_a_cyc && m_starve == LIM)) g = 2;
      else if (i_a_cyc) g = 1;
      else g = 0;
    end
    if (!i_a_cyc) m_starve = 0;
    else if (arb && g == 1) m_starve = 0;
    else if (arb && g == 2) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
    m_owner = g;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit oa, ob;
    oa = (m_owner == 1);
    ob = (m_owner == 2);
    e.cyc     = oa ? i_a_cyc : ob ? i_b_cyc : 1'b0;
    e.stb     = oa ? i_a_stb : ob ? i_b_stb : 1'b0;
    e.we      = ob ? i_b_we   : i_a_we;
    e.addr    = ob ? i_b_addr : i_a_addr;
    e.data    = ob ? i_b_data : i_a_data;
    e.a_stall = oa ? i_stall : 1'b1;
    e.b_stall = ob ? i_stall : 1'b1;
    e.a_ack   = oa && i_ack && i_a_cyc;
    e.a_err   = oa && i_err && i_a_cyc;
    e.b_ack   = ob && i_ack && i_b_cyc;
    e.b_err   = ob && i_err && i_b_cyc;
    e.owner   = 2'(m_owner);
    e.starve  = m_starve;
    return e;
  endfunction

  task automatic step(input logic rst_n, input logic acyc, input logic astb,
                      input logic bcyc, input logic bstb, input logic ack,
                      input logic err, input logic stall);
    @(posedge clk);
    #1;
    model_edge();
    i_rst_n  = rst_n;
    i_a_cyc  = acyc;
    i_a_stb  = astb;
    i_b_cyc  = bcyc;
    i_b_stb  = bstb;
    i_ack    = ack;
    i_err    = err;
    i_stall  = stall;
    i_a_we   = 1'($urandom);
    i_b_we   = 1'($urandom);
    i_a_addr = AW'($urandom);
    i_b_addr = AW'($urandom);
    i_a_data = $urandom;
    i_b_data = $urandom;
    q.push_back(model_out());
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("owner", o_owner, e.owner);
      chk("cyc", o_cyc, e.cyc);
      chk("stb", o_stb, e.stb);
      chk("a_stall", o_a_stall, e.a_stall);
      chk("b_stall", o_b_stall, e.b_stall);
      chk("a_ack", o_a_ack, e.a_ack);
      chk("b_ack", o_b_ack, e.b_ack);
      chk("a_err", o_a_err, e.a_err);
      chk("b_err", o_b_err, e.b_err);
      chk("starve", dut.starve_q, e.starve);
      if (e.owner != 0) begin
        chk("we", o_we, e.we);
        chk("addr", o_addr, e.addr);
        chk("data", o_data, e.data);
      end
    end
  end

  initial begin
    bit ga, gb;
    i_rst_n = 1'b0;
    i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = '0;
    i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_addr = '0; i_b_data = '0;
    i_ack = 0; i_err = 0; i_stall = 0;
    // reset
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // A alone, ack routed to A, then release
    step(1, 1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // simultaneous request: B first, A takes over directly
    step(1, 1, 1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // A held while B issues repeated cycles
    for (int k = 0; k < 9; k++) begin
      step(1, 1, 1, 1, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // B error, then reset mid-cycle
    step(1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // owner drops cyc, late ack discarded
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    // random traffic with persistent cycles
    ga = 0;
    gb = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(5) == 0) ga = ~ga;
      if ($urandom_range(4) == 0) gb = ~gb;
      step(($urandom_range(99) != 0), ga, 1'($urandom), gb, 1'($urandom),
           1'($urandom), ($urandom_range(7) == 0), 1'($urandom));
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
